// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline control blocks.
// The register-match helper decides whether an older instruction's destination feeds a source read in ID.
package pipeline_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero never creates a dependency, and an unread source never matches.
  function automatic logic reg_match(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// There is no valid/ready handshake here: every output is a level, valid in the cycle its inputs are valid.
interface hazard_controller_if;
  import pipeline_pkg::*;

  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        ID_IsBranch;
  logic        ID_BranchTaken;
  logic        ID_IsMulDiv;
  logic        ID_IsDiv;
  logic        ID_ReadsHiLo;
  logic        ID_EX_MemRead;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_Rd;
  logic        EX_MEM_MemRead;
  logic [4:0]  EX_MEM_Rd;

  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        MDU_Start;
  logic        MDU_Busy;
  logic        MDU_Done;
  logic [31:0] StallCount;
  mdu_state_t  mdu_state;

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchTaken,
           ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo, ID_EX_MemRead, ID_EX_RegWrite,
           ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MDU_Start, MDU_Busy,
           MDU_Done, StallCount, mdu_state
  );

  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchTaken,
           ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo, ID_EX_MemRead, ID_EX_RegWrite,
           ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MDU_Start, MDU_Busy,
           MDU_Done, StallCount, mdu_state
  );

endinterface

// File: rtl/hazard_controller_mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer: counts the MDU busy window and emits Start/Busy/Done.
// Busy covers N cycles beginning with the Start cycle; Done marks the last of them.
module mdu_sequencer
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic       is_div,
  output logic       start,
  output logic       busy,
  output logic       done,
  output mdu_state_t state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      start <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      start <= issue && (state == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_raw   = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_next = BUSY;
          cnt_next   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done_raw   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset aborts a running operation at once, so Busy/Done drop while reset is high.
  assign busy = (state == BUSY) && !reset;
  assign done = done_raw && !reset;

endmodule

// File: rtl/hazard_controller.sv
// Hazard detection for the five-stage core: load-use, branch-after-load and MDU stalls,
// branch flush, MDU sequencing and a free-running stall-cycle counter.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  logic        ex_hit;
  logic        mem_hit;
  logic        load_use_stall;
  logic        branch_stall;
  logic        mdu_stall;
  logic        stall;
  logic        issue;
  logic        mdu_start;
  logic        mdu_busy;
  logic        mdu_done;
  mdu_state_t  mdu_state;
  logic [31:0] stall_count;

  assign ex_hit  = reg_match(hz.ID_UsesRs, hz.IF_ID_Rs, hz.ID_EX_Rd)
                || reg_match(hz.ID_UsesRt, hz.IF_ID_Rt, hz.ID_EX_Rd);
  assign mem_hit = reg_match(hz.ID_UsesRs, hz.IF_ID_Rs, hz.EX_MEM_Rd)
                || reg_match(hz.ID_UsesRt, hz.IF_ID_Rt, hz.EX_MEM_Rd);

  // ALU results forward into ID from EX/MEM/WB; only load data in flight forces a wait.
  assign load_use_stall = hz.ID_EX_MemRead && ex_hit;
  assign branch_stall   = hz.ID_IsBranch &&
                          ((hz.ID_EX_MemRead && ex_hit) || (hz.EX_MEM_MemRead && mem_hit));
  assign mdu_stall      = mdu_busy && (hz.ID_IsMulDiv || hz.ID_ReadsHiLo);
  assign stall          = load_use_stall || branch_stall || mdu_stall;

  assign issue = hz.ID_IsMulDiv && !stall && !reset;

  mdu_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_sequencer (
    .clk    (clk),
    .reset  (reset),
    .issue  (issue),
    .is_div (hz.ID_IsDiv),
    .start  (mdu_start),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .state  (mdu_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'd0;
    end else if (stall) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  // A stall freezes the front end and hides any taken branch until it clears.
  assign hz.PC_Write     = !reset && !stall;
  assign hz.IF_ID_Write  = !reset && !stall;
  assign hz.IF_ID_Flush  = reset || (!stall && hz.ID_BranchTaken);
  assign hz.ID_EX_Bubble = reset || stall;
  assign hz.MDU_Start    = mdu_start;
  assign hz.MDU_Busy     = mdu_busy;
  assign hz.MDU_Done     = mdu_done;
  assign hz.StallCount   = stall_count;
  assign hz.mdu_state    = mdu_state;

endmodule
